// File: rtl/transaction_layer_rx.sv
// transaction_layer_rx: steers a serialized stream of words into four class
// FIFOs selected by the two top data bits. Flow control back to the link uses
// almost-full and almost-empty thresholds. The block also keeps per-class
// delivered-word counters and a one-hot RESET/INIT/IDLE/ACTIVE sequencer.
module transaction_layer_rx #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [2:0]        Umbral_bajo,
   input  logic [2:0]        Umbral_alto,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic              rx_ready,
   input  logic              pop0,
   input  logic              pop1,
   input  logic              pop2,
   input  logic              pop3,
   output logic [DATA_W-1:0] data_out0,
   output logic [DATA_W-1:0] data_out1,
   output logic [DATA_W-1:0] data_out2,
   output logic [DATA_W-1:0] data_out3,
   output logic              empty0,
   output logic              empty1,
   output logic              empty2,
   output logic              empty3,
   output logic              almost_full0,
   output logic              almost_full1,
   output logic              almost_full2,
   output logic              almost_full3,
   output logic              almost_empty0,
   output logic              almost_empty1,
   output logic              almost_empty2,
   output logic              almost_empty3,
   input  logic              req,
   input  logic [1:0]        idx,
   output logic [CNT_W-1:0]  contador,
   output logic              valid,
   output logic [3:0]        state,
   output logic              idle
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [3:0] {
      S_RESET  = 4'b0001,
      S_INIT   = 4'b0010,
      S_IDLE   = 4'b0100,
      S_ACTIVE = 4'b1000
   } state_t;

   state_t            r_state;
   logic              r_rx_ready;
   logic [2:0]        r_umb_sup;
   logic [2:0]        r_umb_inf;
   logic [DATA_W-1:0] r_mem  [4][DEPTH];
   logic [PTR_W-1:0]  r_wptr [4];
   logic [PTR_W-1:0]  r_rptr [4];
   logic [OCC_W-1:0]  r_occ  [4];
   logic [DATA_W-1:0] r_dout [4];
   logic [CNT_W-1:0]  r_cnt  [4];
   logic [CNT_W-1:0]  r_contador;
   logic              r_valid;

   logic [3:0]        w_pop;
   logic [3:0]        w_empty;
   logic [3:0]        w_afull;
   logic [3:0]        w_aempty;
   logic [3:0]        w_push;
   logic [3:0]        w_pop_ok;
   logic              w_accept;
   logic [1:0]        w_cls;

   assign w_pop    = {pop3, pop2, pop1, pop0};
   assign w_accept = rx_valid & r_rx_ready;
   assign w_cls    = rx_data[DATA_W-1 -: 2];

   // Status flags from registered occupancy plus push/pop qualification per class
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_empty[k]  = (r_occ[k] == '0);
         w_afull[k]  = (r_occ[k] >= OCC_W'(r_umb_sup));
         w_aempty[k] = (r_occ[k] <= OCC_W'(r_umb_inf));
         w_push[k]   = w_accept && (w_cls == 2'(k)) && (r_occ[k] != OCC_W'(DEPTH));
         w_pop_ok[k] = w_pop[k] && !w_empty[k];
      end
   end

   // Sequencer; rx_ready is registered, so it reacts to occupancy one cycle late
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_RESET;
         r_rx_ready <= 1'b0;
      end else begin
         case (r_state)
            S_RESET: begin
               r_state    <= S_INIT;
               r_rx_ready <= 1'b0;
            end
            S_INIT: begin
               if (init) begin
                  r_rx_ready <= 1'b0;
               end else begin
                  r_state    <= S_IDLE;
                  r_rx_ready <= ~|w_afull;
               end
            end
            S_IDLE: begin
               if (init) begin
                  r_state    <= S_INIT;
                  r_rx_ready <= 1'b0;
               end else begin
                  if (w_accept) r_state <= S_ACTIVE;
                  r_rx_ready <= ~|w_afull;
               end
            end
            S_ACTIVE: begin
               if (init) begin
                  r_state    <= S_INIT;
                  r_rx_ready <= 1'b0;
               end else begin
                  if (&w_empty && !w_accept) r_state <= S_IDLE;
                  r_rx_ready <= ~|w_afull;
               end
            end
            default: begin
               r_state    <= S_RESET;
               r_rx_ready <= 1'b0;
            end
         endcase
      end
   end

   // Threshold capture: tracks the inputs for as long as the block sits in INIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_umb_sup <= 3'd6;
         r_umb_inf <= 3'd1;
      end else if (r_state == S_INIT) begin
         r_umb_sup <= Umbral_alto;
         r_umb_inf <= Umbral_bajo;
      end
   end

   // FIFO control: pointers, occupancy, popped-word register and delivered counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 4; k++) begin
            r_wptr[k] <= '0;
            r_rptr[k] <= '0;
            r_occ[k]  <= '0;
            r_dout[k] <= '0;
            r_cnt[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (w_push[k]) r_wptr[k] <= r_wptr[k] + PTR_W'(1);
            if (w_pop_ok[k]) begin
               r_rptr[k] <= r_rptr[k] + PTR_W'(1);
               r_dout[k] <= r_mem[k][r_rptr[k]];
            end
            case ({w_push[k], w_pop_ok[k]})
               2'b10:   r_occ[k] <= r_occ[k] + OCC_W'(1);
               2'b01:   r_occ[k] <= r_occ[k] - OCC_W'(1);
               default: r_occ[k] <= r_occ[k];
            endcase
            if (r_state == S_INIT)  r_cnt[k] <= '0;
            else if (w_pop_ok[k])   r_cnt[k] <= r_cnt[k] + CNT_W'(1);
         end
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (w_push[k]) r_mem[k][r_wptr[k]] <= rx_data;
      end
   end

   // Counter read port returns the value held before any same-cycle increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_contador <= '0;
         r_valid    <= 1'b0;
      end else if (req) begin
         r_contador <= r_cnt[idx];
         r_valid    <= 1'b1;
      end else begin
         r_contador <= '0;
         r_valid    <= 1'b0;
      end
   end

   assign rx_ready      = r_rx_ready;
   assign state         = r_state;
   assign idle          = (r_state == S_IDLE);
   assign contador      = r_contador;
   assign valid         = r_valid;
   assign data_out0     = r_dout[0];
   assign data_out1     = r_dout[1];
   assign data_out2     = r_dout[2];
   assign data_out3     = r_dout[3];
   assign empty0        = w_empty[0];
   assign empty1        = w_empty[1];
   assign empty2        = w_empty[2];
   assign empty3        = w_empty[3];
   assign almost_full0  = w_afull[0];
   assign almost_full1  = w_afull[1];
   assign almost_full2  = w_afull[2];
   assign almost_full3  = w_afull[3];
   assign almost_empty0 = w_aempty[0];
   assign almost_empty1 = w_aempty[1];
   assign almost_empty2 = w_aempty[2];
   assign almost_empty3 = w_aempty[3];

endmodule
